// File: rtl/mc_controller_ws.sv
// Multicycle ARM control unit: main FSM, decode, flag register and condition check,
// with memory wait-state watchdog, multi-cycle multiply and a register write-port vector.
module mc_controller_ws #(
    parameter int unsigned NUM_WPORTS   = 2,
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned MUL_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Instr,
    input  logic [3:0]            ALUFlags,
    input  logic                  MemReady,
    output logic                  MemReq,
    output logic                  MemFault,
    output logic                  PCWrite,
    output logic                  MemWrite,
    output logic [NUM_WPORTS-1:0] RegWrite,
    output logic                  IRWrite,
    output logic                  AdrSrc,
    output logic [1:0]            RegSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ImmSrc,
    output logic [2:0]            ALUControl,
    output logic [3:0]            Flags
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_MUL, S_ALUWB, S_BRANCH, S_FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);
    localparam logic [3:0] MUL_LAST  = 4'(MUL_CYCLES - 1);

    state_t     state, state_next;
    logic       cond_ex;
    logic [7:0] wait_cnt;
    logic [3:0] mul_cnt;
    logic       mul_last, alu_cycle, nz_we, cv_we;
    logic       is_mul, is_cmp, is_arith, rd_pc;
    logic [1:0] op;
    logic [3:0] cmd;
    logic [2:0] alu_dec;
    logic       unused_bits;

    assign op          = Instr[27:26];
    assign cmd         = Instr[24:21];
    assign rd_pc       = (Instr[15:12] == 4'hF);
    assign is_mul      = (op == 2'b00) && !Instr[25] && (Instr[7:4] == 4'b1001);
    assign is_cmp      = (cmd == 4'b1010) && !is_mul;
    assign is_arith    = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
    assign mul_last    = (mul_cnt == MUL_LAST);
    assign ImmSrc      = op;
    assign RegSrc      = {(op == 2'b01) && !Instr[20], op == 2'b10};
    assign unused_bits = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        unique case (c)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return cy;
            4'b0011: return !cy;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return cy && !z;
            4'b1001: return !cy || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        unique case (cmd)
            4'b0100: alu_dec = 3'b000;
            4'b0010: alu_dec = 3'b001;
            4'b1010: alu_dec = 3'b001;
            4'b1100: alu_dec = 3'b011;
            default: alu_dec = 3'b010;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            Flags    <= '0;
            cond_ex  <= 1'b0;
            wait_cnt <= '0;
            mul_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                cond_ex <= cond_check(Instr[31:28], Flags);
            if (nz_we)
                Flags[3:2] <= ALUFlags[3:2];
            if (cv_we)
                Flags[1:0] <= ALUFlags[1:0];
            // Counter restarts whenever the access completes or the FSM moves on.
            if (MemReq && !MemReady && (state_next == state))
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
            if (state == S_MUL && !mul_last)
                mul_cnt <= mul_cnt + 4'd1;
            else
                mul_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        MemReq     = 1'b0;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = '0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        alu_cycle  = 1'b0;
        MemFault   = (state == S_FAULT);
        unique case (state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                unique case (op)
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    2'b00:   state_next = Instr[25] ? S_EXECI : (is_mul ? S_MUL : S_EXECR);
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = Instr[20] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                RegWrite[0] = cond_ex;
                PCWrite     = cond_ex && rd_pc;
                state_next  = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = cond_ex && MemReady;
                if (MemReady)
                    state_next = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_dec;
                alu_cycle  = 1'b1;
                state_next = S_ALUWB;
            end
            S_MUL: begin
                ALUControl = 3'b100;
                alu_cycle  = mul_last;
                if (mul_last)
                    state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite[0] = cond_ex && (is_mul || !is_cmp);
                RegWrite[1] = cond_ex && is_mul && Instr[23];
                PCWrite     = cond_ex && (is_mul || !is_cmp) && rd_pc;
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCWrite    = cond_ex;
                state_next = S_FETCH;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FETCH;
        endcase
        if (MemReq && !MemReady && (wait_cnt == WAIT_LAST))
            state_next = S_FAULT;
        // Multiply results only carry N and Z; logical ops likewise leave C and V alone.
        nz_we = alu_cycle && cond_ex && (Instr[20] || is_cmp);
        cv_we = nz_we && (state != S_MUL) && is_arith;
    end

endmodule
